// File: rtl/crc32_engine_if.sv
// crc32_engine_if: handshake/bus bundle for crc32_engine.
//   master : client side (drives start/abort/beat, observes result)
//   slave  : engine side
// Signals: start_i, abort_i, val_i/rdy_o beat handshake, dat_i/num_i/lst_i beat
// payload, val_o/dat_o/done_o result, busy_o status.
// Optional CRC32_SEED_EN adds seed_i (resume from a prior finalised CRC).
interface crc32_engine_if #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned NUM_WD  = 2
);
    logic               start_i;
    logic               abort_i;
    logic               val_i;
    logic               rdy_o;
    logic [DATA_WD-1:0] dat_i;
    logic [NUM_WD-1:0]  num_i;
    logic               lst_i;
    logic               val_o;
    logic [31:0]        dat_o;
    logic               done_o;
    logic               busy_o;
`ifdef CRC32_SEED_EN
    logic [31:0]        seed_i;

    modport master (
        output start_i, abort_i, val_i, dat_i, num_i, lst_i, seed_i,
        input  rdy_o, val_o, dat_o, done_o, busy_o
    );

    modport slave (
        input  start_i, abort_i, val_i, dat_i, num_i, lst_i, seed_i,
        output rdy_o, val_o, dat_o, done_o, busy_o
    );
`else
    modport master (
        output start_i, abort_i, val_i, dat_i, num_i, lst_i,
        input  rdy_o, val_o, dat_o, done_o, busy_o
    );

    modport slave (
        input  start_i, abort_i, val_i, dat_i, num_i, lst_i,
        output rdy_o, val_o, dat_o, done_o, busy_o
    );
`endif
endinterface

// File: rtl/crc32_engine.sv
// crc32_engine: PNG/zlib CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, reflected
// in/out, final XOR 0xFFFFFFFF) over DATA_WD-bit beats, BPC bytes per clock.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   bus    : crc32_engine_if.slave
//            start_i/abort_i control, val_i/rdy_o beat handshake,
//            dat_i (MSB byte first), num_i (n+1 leading bytes valid), lst_i,
//            val_o/done_o result pulses, dat_o finalised CRC, busy_o.
// Optional feature macro: CRC32_SEED_EN (seed_i loads the CRC register on start).
// The CRC register holds the non-reflected form; input bytes are bit-reflected
// before folding and dat_o is reflected and inverted combinationally.
module crc32_engine #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned BPC     = 1,
    parameter int unsigned NUM_WD  = (DATA_WD <= 16) ? 1 : $clog2(DATA_WD / 8)
) (
    input  logic            clk,
    input  logic            rst,
    crc32_engine_if.slave   bus
);

    localparam int unsigned NBYTES  = DATA_WD / 8;
    localparam int unsigned STEPS   = NBYTES / BPC;
    localparam int unsigned STEP_WD = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned BIT_WD  = $clog2(DATA_WD);
    localparam logic [31:0] POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] ALL1    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACTV = 2'd1,
        S_PROC = 2'd2
    } state_e;

    state_e               state_q;
    state_e               state_d;

    logic [31:0]          crc_q;
    logic [31:0]          crc_fold;
    logic [31:0]          crc_init;
    logic [DATA_WD-1:0]   beat_q;
    logic [NUM_WD-1:0]    num_q;
    logic                 lst_q;
    logic [STEP_WD-1:0]   step_q;
    logic                 val_q;
    logic                 done_q;

    logic                 last_step;
    logic                 rdy;
    logic                 accept;
    logic                 load;
    logic                 fold_en;
    logic                 fin;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = x[7-i];
        end
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

    // One byte through the MSB-first CRC shift register.
    function automatic logic [31:0] fold_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {rev8(b), 24'h0};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    assign last_step = (step_q == STEP_WD'(STEPS - 1));
    assign accept    = rdy & bus.val_i;

`ifdef CRC32_SEED_EN
    // Undo the finalisation so a previous dat_o resumes the running CRC.
    assign crc_init = rev32(bus.seed_i ^ ALL1);
`else
    assign crc_init = ALL1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over a beat, start only counts in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_i) state_d = S_ACTV;
            end
            S_ACTV: begin
                if (bus.abort_i)    state_d = S_IDLE;
                else if (bus.val_i) state_d = S_PROC;
            end
            S_PROC: begin
                if (bus.abort_i)    state_d = S_IDLE;
                else if (last_step) state_d = lst_q ? S_IDLE : S_ACTV;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        rdy     = 1'b0;
        load    = 1'b0;
        fold_en = 1'b0;
        fin     = 1'b0;
        case (state_q)
            S_IDLE: load = bus.start_i;
            S_ACTV: rdy  = ~bus.abort_i;
            S_PROC: begin
                fold_en = ~bus.abort_i;
                fin     = ~bus.abort_i & last_step;
            end
            default: ;
        endcase
    end

    // Fold this step's BPC-byte group; bytes past num_q leave the CRC alone.
    always_comb begin
        logic [31:0]       c;
        int unsigned       idx;
        logic [BIT_WD-1:0] lsb;
        c   = crc_q;
        idx = 0;
        lsb = '0;
        for (int unsigned k = 0; k < BPC; k++) begin
            idx = 32'(step_q) * BPC + k;
            lsb = BIT_WD'(DATA_WD - 8 - 8 * idx);
            if (idx <= 32'(num_q)) begin
                c = fold_byte(c, beat_q[lsb +: 8]);
            end
        end
        crc_fold = c;
    end

    // Datapath: beat capture, step counter, CRC register, result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q  <= '0;
            beat_q <= '0;
            num_q  <= '0;
            lst_q  <= 1'b0;
            step_q <= '0;
            val_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            val_q  <= fin;
            done_q <= fin & lst_q;
            if (load) begin
                crc_q <= crc_init;
            end else if (fold_en) begin
                crc_q <= crc_fold;
            end
            if (accept) begin
                beat_q <= bus.dat_i;
                num_q  <= bus.num_i;
                lst_q  <= bus.lst_i;
                step_q <= '0;
            end else if (fold_en && !last_step) begin
                step_q <= step_q + STEP_WD'(1);
            end
        end
    end

    assign bus.rdy_o  = rdy;
    assign bus.busy_o = (state_q != S_IDLE);
    assign bus.val_o  = val_q;
    assign bus.done_o = done_q;
    assign bus.dat_o  = rev32(crc_q) ^ ALL1;

endmodule

// File: tb/tb_crc32_engine.sv
// tb_crc32_engine: directed bench for crc32_engine. Four engines
// (32b/BPC1, 32b/BPC4, 32b/BPC2, 8b/BPC1) share one stimulus set; sel picks
// the engine that sees start/abort/val and whose outputs are observed.
module tb_crc32_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, val, lst;
    logic [31:0] dat;
    logic [1:0]  num;
    int          sel;
    int          cyc = 0;
`ifdef CRC32_SEED_EN
    logic [31:0] seed;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc32_engine_if #(.DATA_WD(32), .NUM_WD(2)) if0 ();
    crc32_engine_if #(.DATA_WD(32), .NUM_WD(2)) if1 ();
    crc32_engine_if #(.DATA_WD(32), .NUM_WD(2)) if2 ();
    crc32_engine_if #(.DATA_WD(8),  .NUM_WD(1)) if3 ();

    assign if0.start_i = start & (sel == 0);
    assign if0.abort_i = abort & (sel == 0);
    assign if0.val_i   = val   & (sel == 0);
    assign if0.dat_i   = dat;
    assign if0.num_i   = num;
    assign if0.lst_i   = lst;
    assign if1.start_i = start & (sel == 1);
    assign if1.abort_i = abort & (sel == 1);
    assign if1.val_i   = val   & (sel == 1);
    assign if1.dat_i   = dat;
    assign if1.num_i   = num;
    assign if1.lst_i   = lst;
    assign if2.start_i = start & (sel == 2);
    assign if2.abort_i = abort & (sel == 2);
    assign if2.val_i   = val   & (sel == 2);
    assign if2.dat_i   = dat;
    assign if2.num_i   = num;
    assign if2.lst_i   = lst;
    assign if3.start_i = start & (sel == 3);
    assign if3.abort_i = abort & (sel == 3);
    assign if3.val_i   = val   & (sel == 3);
    assign if3.dat_i   = dat[31:24];
    assign if3.num_i   = num[0];
    assign if3.lst_i   = lst;
`ifdef CRC32_SEED_EN
    assign if0.seed_i = seed;
    assign if1.seed_i = seed;
    assign if2.seed_i = seed;
    assign if3.seed_i = seed;
`endif

    crc32_engine #(.DATA_WD(32), .BPC(1), .NUM_WD(2)) u_bpc1 (.clk(clk), .rst(rst), .bus(if0));
    crc32_engine #(.DATA_WD(32), .BPC(4), .NUM_WD(2)) u_bpc4 (.clk(clk), .rst(rst), .bus(if1));
    crc32_engine #(.DATA_WD(32), .BPC(2), .NUM_WD(2)) u_bpc2 (.clk(clk), .rst(rst), .bus(if2));
    crc32_engine #(.DATA_WD(8),  .BPC(1), .NUM_WD(1)) u_w8   (.clk(clk), .rst(rst), .bus(if3));

    logic        m_rdy, m_val, m_done, m_busy;
    logic [31:0] m_dat;

    always_comb begin
        case (sel)
            1:       begin m_rdy = if1.rdy_o; m_val = if1.val_o; m_done = if1.done_o; m_busy = if1.busy_o; m_dat = if1.dat_o; end
            2:       begin m_rdy = if2.rdy_o; m_val = if2.val_o; m_done = if2.done_o; m_busy = if2.busy_o; m_dat = if2.dat_o; end
            3:       begin m_rdy = if3.rdy_o; m_val = if3.val_o; m_done = if3.done_o; m_busy = if3.busy_o; m_dat = if3.dat_o; end
            default: begin m_rdy = if0.rdy_o; m_val = if0.val_o; m_done = if0.done_o; m_busy = if0.busy_o; m_dat = if0.dat_o; end
        endcase
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ev_dat[$];
    bit          ev_done[$];
    int          ev_cyc[$];

    // Record every result pulse of the selected engine.
    always @(negedge clk) begin
        if (m_val === 1'b1) begin
            ev_dat.push_back(m_dat);
            ev_done.push_back(m_done);
            ev_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference CRC-32, LSB-first with the reflected polynomial.
    function automatic logic [31:0] ref_crc(input string s);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < s.len(); i++) begin
            c = c ^ {24'h0, s[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    function automatic void clear_ev();
        ev_dat.delete();
        ev_done.delete();
        ev_cyc.delete();
    endfunction

    // All tasks start and end at posedge+1.
    task automatic start_msg();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [1:0] n, input logic l,
                             input bit garb, output int acc);
        bit ok;
        ok  = 1'b0;
        val = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (garb) begin
                dat = $urandom;
                num = 2'($urandom);
                lst = 1'($urandom);
            end else begin
                dat = d; num = n; lst = l;
            end
            @(negedge clk);
            if (m_rdy === 1'b1) begin
                dat = d; num = n; lst = l;
                ok  = 1'b1;
            end
            @(posedge clk); #1;
        end
        acc = cyc;
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_events(input int n);
        for (int i = 0; i < 60 && ev_dat.size() < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_digits(input bit garb, input int steps, input string tag);
        int a0, a1, a2;
        clear_ev();
        start_msg();
        send_beat(32'h3132_3334, 2'd3, 1'b0, garb, a0);
        send_beat(32'h3536_3738, 2'd3, 1'b0, garb, a1);
        send_beat(32'h39A5_C3E1, 2'd0, 1'b1, garb, a2);
        val = 1'b0;
        wait_events(3);
        if (ev_dat.size() == 3) begin
            check({tag, "_crc_1234"},     ev_dat[0], ref_crc("1234"));
            check({tag, "_crc_12345678"}, ev_dat[1], ref_crc("12345678"));
            check({tag, "_crc_final"},    ev_dat[2], 32'hCBF4_3926);
            check({tag, "_done_flags"},   {29'h0, ev_done[0], ev_done[1], ev_done[2]}, 32'h1);
            check({tag, "_latency"},      32'(ev_cyc[2] - a2), 32'(steps));
            check({tag, "_spacing01"},    32'(a1 - a0), 32'(steps + 1));
            check({tag, "_spacing12"},    32'(a2 - a1), 32'(steps + 1));
        end else begin
            check({tag, "_event_count"}, 32'(ev_dat.size()), 32'd3);
        end
        check({tag, "_idle_after"}, {31'h0, m_busy}, 32'h0);
    endtask

    task automatic run_single(input logic [31:0] d, input logic [1:0] n, input logic [31:0] exp,
                              input int steps, input bit poke_start, input string tag);
        int a;
        clear_ev();
        start_msg();
        send_beat(d, n, 1'b1, 1'b0, a);
        val = 1'b0;
        if (poke_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_events(1);
        if (ev_dat.size() == 1) begin
            check({tag, "_crc"},     ev_dat[0], exp);
            check({tag, "_done"},    {31'h0, ev_done[0]}, 32'h1);
            check({tag, "_latency"}, 32'(ev_cyc[0] - a), 32'(steps));
        end else begin
            check({tag, "_event_count"}, 32'(ev_dat.size()), 32'd1);
        end
    endtask

    initial begin
        int a;
        rst = 1'b1; start = 1'b0; abort = 1'b0; val = 1'b0; lst = 1'b0;
        dat = '0; num = '0; sel = 0;
`ifdef CRC32_SEED_EN
        seed = '0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check("rst_dat",   m_dat, 32'hFFFF_FFFF);
            check("rst_flags", {28'h0, m_rdy, m_val, m_done, m_busy}, 32'h0);
        end
        sel = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        sel = 0; run_digits(1'b0, 4, "bpc1");
        sel = 1; run_digits(1'b0, 1, "bpc4");
        sel = 2; run_digits(1'b0, 2, "bpc2");

        sel = 0; run_single(32'h4945_4E44, 2'd3, 32'hAE42_6082, 4, 1'b1, "iend");
        sel = 0; run_single(32'h61FF_EEDD, 2'd0, 32'hE8B7_BE43, 4, 1'b0, "byte_a");
        sel = 3; run_single(32'h6100_0000, 2'd0, 32'hE8B7_BE43, 1, 1'b0, "w8_a");
        sel = 2; run_single(32'h3132_33FF, 2'd2, ref_crc("123"), 2, 1'b0, "bpc2_part");
        sel = 1; run_single(32'h3132_33FF, 2'd2, ref_crc("123"), 1, 1'b0, "bpc4_part");
        sel = 1; run_single(32'h3100_0000, 2'd0, ref_crc("1"),   1, 1'b0, "bpc4_one");

        sel = 0; run_digits(1'b1, 4, "bp_bpc1");
        sel = 2; run_digits(1'b1, 2, "bp_bpc2");

        // Abort in PROC step 1, abort against a beat, start+abort, rst mid-message.
        sel = 0;
        clear_ev();
        start_msg();
        send_beat(32'h3132_3334, 2'd3, 1'b0, 1'b0, a);
        val = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", {31'h0, m_busy}, 32'h0);
        start_msg();
        abort = 1'b1; val = 1'b1; dat = 32'h3536_3738; num = 2'd3; lst = 1'b1;
        @(negedge clk);
        check("abort_rdy", {31'h0, m_rdy}, 32'h0);
        @(posedge clk); #1;
        abort = 1'b0; val = 1'b0;
        check("abort_beats_val", {31'h0, m_busy}, 32'h0);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start_wins", {31'h0, m_busy}, 32'h1);
        send_beat(32'h3132_3334, 2'd3, 1'b0, 1'b0, a);
        val = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_dat",   m_dat, 32'hFFFF_FFFF);
        check("midrst_flags", {29'h0, m_rdy, m_val, m_busy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_pulses_after_abort", 32'(ev_dat.size()), 32'd0);
        run_digits(1'b0, 4, "post_rst");

`ifdef CRC32_SEED_EN
        sel = 0;
        seed = '0;
        clear_ev();
        start_msg();
        send_beat(32'h3132_3334, 2'd3, 1'b0, 1'b0, a);
        send_beat(32'h3500_0000, 2'd0, 1'b1, 1'b0, a);
        val = 1'b0;
        wait_events(2);
        if (ev_dat.size() == 2) check("seed_part1", ev_dat[1], ref_crc("12345"));
        else check("seed_part1_count", 32'(ev_dat.size()), 32'd2);
        seed = ref_crc("12345");
        run_single(32'h3637_3839, 2'd3, 32'hCBF4_3926, 4, 1'b0, "seed_resume");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/crc32_engine.md
Name: crc32_engine

Overview:
- Parametrised CRC-32 engine (PNG/zlib CRC: poly 0x04C11DB7, init 0xFFFFFFFF, reflected in/out, final XOR 0xFFFFFFFF) for the PNG chunk writer.
- Generalises the fixed 32-bit, 1-byte-per-cycle CRC core:
  - configurable beat width and bytes folded per cycle;
  - ready/valid backpressure and abort;
  - per-beat running-CRC output.

Parameters:
- DATA_WD, 32, beat width in bits; multiple of 8, 8..128; NBYTES = DATA_WD/8.
- BPC, 1, bytes folded per clock; power of two, divides NBYTES; STEPS = NBYTES/BPC.
- NUM_WD, max(1,clog2(NBYTES)), width of num_i.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  begin new CRC; honoured in IDLE only.
- abort_i  in  1  drop current CRC, return to IDLE; honoured in any non-IDLE state.
- val_i  in  1  input beat valid.
- rdy_o  out  1  engine can accept a beat.
- dat_i  in  DATA_WD  beat; byte dat_i[DATA_WD-1 -: 8] is processed first.
- num_i  in  NUM_WD  value n: the n+1 most significant bytes are valid.
- lst_i  in  1  beat is the last of the message.
- val_o  out  1  one-cycle pulse; dat_o holds the CRC after the beat just finished.
- dat_o  out  32  finalised CRC (reflected, XORed) of all bytes so far.
- done_o  out  1  one-cycle pulse with val_o on the last beat.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (rst high, async): state IDLE, CRC register 0, rdy_o/val_o/done_o/busy_o 0, dat_o = 0xFFFFFFFF (finalised form of 0).
- States and transitions:
  - IDLE: start_i -> ACTV, CRC register <= 0xFFFFFFFF.
  - ACTV: rdy_o=1; val_i&&rdy_o latches dat_i/num_i/lst_i and goes to PROC, step counter = 0.
  - PROC: rdy_o=0; each cycle folds bytes step*BPC .. step*BPC+BPC-1 (MSB-first order), each byte bit-reflected before folding.
  - PROC exit: after step STEPS-1 -> ACTV, or -> IDLE if the latched lst is set.
- Valid bytes: only bytes with index <= latched num are folded; bytes beyond are skipped and leave the CRC unchanged. A BPC group that is only partially valid folds its valid bytes only, so any num is exact.
- Latency and throughput:
  - Beat accepted at edge T; folding occurs on edges T+1 .. T+STEPS.
  - val_o=1 during cycle T+STEPS+1 (registered); dat_o valid while val_o=1 and stable until the next fold.
  - Max throughput: one beat per STEPS+1 cycles.
- done_o asserts together with val_o for the last beat. The engine is already in IDLE that cycle and can take start_i immediately.
- dat_o is combinational: bit-reverse(CRC register) ^ 0xFFFFFFFF.
- Boundary conditions:
  - abort_i: next edge -> IDLE; no val_o/done_o for the in-flight beat; the CRC register is kept but meaningless. abort_i beats val_i in the same cycle (beat not accepted, rdy_o forced 0 while abort_i=1).
  - start_i outside IDLE: ignored.
  - start_i and abort_i together in IDLE: start wins.
  - val_i in IDLE: ignored, rdy_o=0.
  - rst mid-message: returns to reset values immediately; no pulses.
- Rule: dat_i/num_i/lst_i need only be stable in the accept cycle.

Optional Feature:
- CRC32_SEED_EN defined:
  - adds input seed_i [31:0];
  - on start_i the CRC register loads bit-reverse(seed_i ^ 0xFFFFFFFF), so a prior finalised CRC can resume a message split across chunks;
  - seed_i = 0 yields standard init.
- Not defined: no seed_i port; init is always 0xFFFFFFFF.

Test Plan:
- DATA_WD=32, BPC=1: start; beats 0x31323334 n=3, 0x35363738 n=3, 0x39xxxxxx n=0 lst=1 -> final val_o/done_o with dat_o=0xCBF43926; intermediate val_o after each beat; 5-cycle beat spacing.
- Same stream with BPC=4 and with BPC=2 -> dat_o=0xCBF43926; beat spacing 2 and 3 cycles; done_o one cycle after the last fold.
- Single beat 0x49454E44 n=3 lst=1 ("IEND") -> dat_o=0xAE426082; single byte 0x61 n=0 lst=1 -> 0xE8B7BE43; DATA_WD=8 "a" -> 0xE8B7BE43.
- Backpressure: val_i held high continuously with random garbage in the non-accepted cycles -> only rdy_o cycles accepted; result unchanged 0xCBF43926.
- abort_i in PROC step 1, then rst pulse mid-message, then a fresh start with "123456789" -> no val_o/done_o for the aborted message; correct 0xCBF43926 afterwards; dat_o=0xFFFFFFFF right after rst.
- CRC32_SEED_EN: "12345" then new start with seed_i=CRC("12345"), message "6789" -> dat_o=0xCBF43926.
